// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences IF/ID, ID/EX, EX/MEM, MEM/WB enables/flushes for
// load-use stalls, taken-branch redirects and data-memory wait. Define PIPE_PERF_EN for counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned       WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [REG_W-1:0]  ZERO_IDX   = REG_W'(ZERO_REG);

    typedef enum logic [1:0] {
        StRun,
        StLuStall,
        StFlush,
        StMemWait
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu_hit;
    logic              lu_check;

    always_comb begin
        lu_hit = ex_mem_read && (ex_rd != ZERO_IDX) &&
                 ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    end

    // The cycle after a stall or flush, ID holds a replayed or bubbled instruction.
    always_comb begin
        lu_check = 1'b0;
        unique case (state_q)
            StRun:     lu_check = 1'b1;
            StMemWait: lu_check = 1'b1;
            StLuStall: lu_check = 1'b0;
            StFlush:   lu_check = 1'b0;
            default:   lu_check = 1'b0;
        endcase
    end

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        state_d       = StRun;
        wait_ctr_d    = '0;
        mem_timeout_d = mem_timeout_q;

        if (!reset) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            ifid_flush    = 1'b1;
            idex_en       = 1'b0;
            idex_flush    = 1'b1;
            exmem_en      = 1'b0;
            memwb_en      = 1'b0;
            mem_timeout_d = 1'b0;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = StMemWait;
            wait_ctr_d = (wait_ctr_q == WAIT_LIMIT) ? wait_ctr_q
                                                    : wait_ctr_q + WAIT_W'(1);
            if (wait_ctr_d == WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
            end
        end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = StFlush;
        end else if (lu_check && lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StLuStall;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StRun;
            wait_ctr_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_ctr_q    <= wait_ctr_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!mem_busy && br_taken && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // A flushed register must still load, otherwise the bubble never enters.
    a_ifid_flush_en: assert property (@(posedge clk) !reset || !ifid_flush || ifid_en);
    a_idex_flush_en: assert property (@(posedge clk) !reset || !idex_flush || idex_en);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks, expected outputs queued on drive
// and popped at the opposite clock edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned MAX_WAIT = 64;
    localparam int unsigned CNT_W    = 16;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] V_RUN = 7'b1101011;
    localparam logic [6:0] V_LU  = 7'b0001111;
    localparam logic [6:0] V_BR  = 7'b1111111;
    localparam logic [6:0] V_FRZ = 7'b0000000;
    localparam logic [6:0] V_RST = 7'b0010100;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic       br;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic [6:0] want;
        logic       to;
    } cyc_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_use_rs2, ex_mem_read, br_taken, mem_busy;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       outs;

    logic [7:0]       sb_q[$];
    logic [7:0]       want;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;
    int               n_run  = 0;
    int               n_fail = 0;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    function automatic cyc_t mk(input logic rst, input logic busy, input logic br,
                                input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic use2,
                                input logic [6:0] w, input logic to);
        cyc_t c;
        c.rst  = rst;
        c.busy = busy;
        c.br   = br;
        c.mr   = mr;
        c.rd   = rd;
        c.rs1  = rs1;
        c.rs2  = rs2;
        c.use2 = use2;
        c.want = w;
        c.to   = to;
        return c;
    endfunction

    task automatic apply(input cyc_t c);
        @(posedge clk);
        #1;
        reset       = c.rst;
        mem_busy    = c.busy;
        br_taken    = c.br;
        ex_mem_read = c.mr;
        ex_rd       = c.rd;
        id_rs1      = c.rs1;
        id_rs2      = c.rs2;
        id_use_rs2  = c.use2;
        sb_q.push_back({c.want, c.to});
    endtask

    // Expected counter values after this cycle's clock edge.
    task automatic count_update(input cyc_t c);
        if (!c.rst) begin
            exp_stall = '0;
            exp_flush = '0;
        end
`ifdef PIPE_PERF_EN
        else begin
            if (!c.want[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
            if (c.want == V_BR && exp_flush != '1) exp_flush = exp_flush + 1'b1;
        end
`endif
    endtask

    task automatic test_reset();
        cyc_t seq[$];
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, V_RST, 0));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL reset_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    task automatic test_load_use();
        cyc_t seq[$];
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 0, 3, 3, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 7, 1, 7, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 31, 31, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 31, 1, 31, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 1, 3, 0, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 0, 3, 3, 3, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL load_use_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    task automatic test_branch();
        cyc_t seq[$];
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 2, 1, V_BR, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 2, 1, V_BR, 0));
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 2, 1, V_BR, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL branch_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    task automatic test_mem_wait();
        cyc_t seq[$];
        for (int i = 0; i < 5; i++) seq.push_back(mk(1, 1, 1, 0, 0, 1, 2, 1, V_FRZ, 0));
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 2, 1, V_BR, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 1, 0, 1, 3, 3, 2, 1, V_FRZ, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, V_FRZ, 0));
        seq.push_back(mk(1, 0, 0, 1, 3, 3, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL mem_wait_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    task automatic test_back_to_back();
        cyc_t seq[$];
        seq.push_back(mk(1, 0, 0, 1, 4, 4, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 0, 1, 4, 4, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 0, 1, 4, 4, 2, 1, V_LU, 0));
        seq.push_back(mk(1, 0, 0, 1, 4, 4, 2, 1, V_RUN, 0));
        seq.push_back(mk(1, 0, 1, 1, 4, 4, 2, 1, V_BR, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL b2b_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    task automatic test_timeout();
        cyc_t seq[$];
        // One short of the limit, a gap, then a few more: the counter must restart.
        for (int i = 0; i < MAX_WAIT - 1; i++)
            seq.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, V_FRZ, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, V_FRZ, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < MAX_WAIT + 6; i++)
            seq.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, V_FRZ, logic'(i >= MAX_WAIT)));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, V_FRZ, 1));
        seq.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, V_RST, 1));
        seq.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, V_RUN, 0));
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i]);
            @(negedge clk);
            want = sb_q.pop_front();
            n_run++;
            if ({outs, mem_timeout} !== want) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b want %b", i, {outs, mem_timeout}, want);
            end
            n_run++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                n_fail++;
                $display("FAIL timeout_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall, exp_flush);
            end
            count_update(seq[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        mem_busy    = 1'b0;
        br_taken    = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = '0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs2  = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
